// File: rtl/dxm_demux_reg.sv
// dxm_demux_reg: registered 1-to-2 demultiplexer.
// Accepts a valid/ready stream and tags each beat with the `control` value
// sampled when it is accepted. Beats sit in a 2-entry in-order buffer and
// leave on the low (tag 0) or high (tag 1) output port. The port that is not
// valid drives zeros, so neither stale nor foreign data is ever exposed.
module dxm_demux_reg #(
    parameter int mux_width = 1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 in_valid,
    input  logic [mux_width-1:0] in_data,
    output logic                 in_ready,
    input  logic                 control,

    output logic                 out_low_valid,
    output logic [mux_width-1:0] out_low_data,
    input  logic                 out_low_ready,

    output logic                 out_high_valid,
    output logic [mux_width-1:0] out_high_data,
    input  logic                 out_high_ready
);

    // Two {data, tag} entries addressed by 1-bit pointers.
    logic [mux_width-1:0] entry_data [2];
    logic                 entry_tag  [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;

    logic                 empty;
    logic                 full;
    logic                 head_tag;
    logic [mux_width-1:0] head_data;
    logic                 push;
    logic                 pop;

    // Head decode, handshakes and port outputs.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        empty          = (count == 2'd0);
        full           = (count == 2'd2);
        head_tag       = entry_tag[rd_ptr];
        head_data      = entry_data[rd_ptr];

        out_low_valid  = 1'b0;
        out_high_valid = 1'b0;
        out_low_data   = '0;
        out_high_data  = '0;

        if (!empty) begin
            if (head_tag) begin
                out_high_valid = 1'b1;
                out_high_data  = head_data;
            end else begin
                out_low_valid  = 1'b1;
                out_low_data   = head_data;
            end
        end

        // Only the ready of the port the head is steered to can pop it.
        pop      = (out_low_valid  && out_low_ready) ||
                   (out_high_valid && out_high_ready);

        // Ready-through on a pop when full; independent of in_valid.
        in_ready = !rst && (!full || pop);
        push     = in_valid && in_ready;
    end

    // Entry storage: written on push only.
    // NOTE: the entries carry no reset; outputs are gated by count, so stale
    // contents are never visible and the storage stays plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_data[wr_ptr] <= in_data;
            entry_tag[wr_ptr]  <= control;
        end
    end

    // Pointer and occupancy bookkeeping with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dxm_demux_reg.sv
// Self-checking bench for dxm_demux_reg (mux_width = 8).
// A queue of {data, tag} beats serves as the reference: the head decides
// which port is valid and what it shows; ready, push and pop follow from
// the queue depth and the consumer readies.
module tb_dxm_demux_reg;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        logic         tag;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         control;
    logic         out_low_valid;
    logic [W-1:0] out_low_data;
    logic         out_low_ready;
    logic         out_high_valid;
    logic [W-1:0] out_high_data;
    logic         out_high_ready;

    int    errors = 0;
    int    checks = 0;
    beat_t q[$];

    dxm_demux_reg #(.mux_width(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .control        (control),
        .out_low_valid  (out_low_valid),
        .out_low_data   (out_low_data),
        .out_low_ready  (out_low_ready),
        .out_high_valid (out_high_valid),
        .out_high_data  (out_high_data),
        .out_high_ready (out_high_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [W-1:0] d,
                         input logic ctl, input logic lr, input logic hr);
        rst            = r;
        in_valid       = iv;
        in_data        = d;
        control        = ctl;
        out_low_ready  = lr;
        out_high_ready = hr;
    endtask

    // Compare the DUT against the queue mid-cycle, then advance the queue
    // by this cycle's handshakes and move to just after the next edge.
    task automatic cycle();
        logic         has_head;
        beat_t        head;
        logic         exp_pop;
        logic         exp_ready;
        logic         exp_lv;
        logic         exp_hv;
        @(negedge clk);
        if (rst) begin
            check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
            q.delete();
        end else begin
            has_head  = (q.size() != 0);
            head.data = '0;
            head.tag  = 1'b0;
            if (has_head) head = q[0];
            exp_lv    = has_head && !head.tag;
            exp_hv    = has_head &&  head.tag;
            exp_pop   = (exp_lv && out_low_ready) || (exp_hv && out_high_ready);
            exp_ready = (q.size() < 2) || exp_pop;
            check("in_ready",       {31'd0, in_ready},       {31'd0, exp_ready});
            check("out_low_valid",  {31'd0, out_low_valid},  {31'd0, exp_lv});
            check("out_high_valid", {31'd0, out_high_valid}, {31'd0, exp_hv});
            check("out_low_data",   {24'd0, out_low_data},   exp_lv ? {24'd0, head.data} : 32'd0);
            check("out_high_data",  {24'd0, out_high_data},  exp_hv ? {24'd0, head.data} : 32'd0);
            if (exp_pop) void'(q.pop_front());
            if (in_valid && exp_ready) begin
                head.data = in_data;
                head.tag  = control;
                q.push_back(head);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;

        // Reset for two cycles, then idle.
        repeat (2) cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle();

        // One beat each way with both consumers ready.
        drive(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1); cycle();
        drive(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1); cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1); repeat (2) cycle();

        // Fill with both readies low, offer a third beat, then release low once.
        drive(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0); repeat (2) cycle();
        drive(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1); repeat (3) cycle();

        // Head-of-line blocking: low stalled, high ready.
        drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1); cycle();
        drive(1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1); cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); repeat (3) cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1); repeat (3) cycle();

        // Back-to-back stream with alternating tags; wraps the pointers.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'(i % 2), 1'b1, 1'b1);
            cycle();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1); repeat (2) cycle();

        // Reset while full, then a fresh beat must route normally.
        drive(1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1); cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1); repeat (2) cycle();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 3) != 0),
                  8'($urandom),
                  1'($urandom),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 2) != 0));
            cycle();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1); repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
